// File: rtl/wam_pkg.sv
// Shared types and default constants for the whack-a-mole front-panel input block.
package wam_pkg;

    typedef enum logic [1:0] {
        LVL_EASY = 2'd0,
        LVL_MED  = 2'd1,
        LVL_HARD = 2'd2
    } wam_lvl_e;

    localparam int unsigned WAM_N_CH          = 8;
    localparam int unsigned WAM_LEVELS        = 3;
    localparam int unsigned WAM_LVL_W         = 4;
    localparam int unsigned WAM_SCAN_DIV_LOG2 = 19;
    localparam int unsigned WAM_DEB_SAMPLES   = 4;

    // Button lanes sit directly above the N_CH switch lanes in the debounce array.
    localparam int unsigned LANE_START_OFS = 0;
    localparam int unsigned LANE_LFT_OFS   = 1;
    localparam int unsigned LANE_RGT_OFS   = 2;
    localparam int unsigned LANE_BTN_CNT   = 3;

    function automatic int unsigned scan_period(input int unsigned div_log2);
        return 32'd1 << div_log2;
    endfunction

endpackage

// File: rtl/wam_panel_io_if.sv
// Board-pin / game-logic bundle for the front-panel input controller.
interface wam_panel_io_if
    import wam_pkg::*;
#(
    parameter int unsigned N_CH  = WAM_N_CH,
    parameter int unsigned LVL_W = WAM_LVL_W
);
    logic             pause;
    logic             lock;
    logic             start;
    logic             lft;
    logic             rgt;
    logic [N_CH-1:0]  sw;
    logic             tick;
    logic [N_CH-1:0]  sw_level;
    logic [N_CH-1:0]  tap;
    logic             go;
    logic [LVL_W-1:0] hrdn;
    logic             hrdn_chg;

    modport master (
        output pause, lock, start, lft, rgt, sw,
        input  tick, sw_level, tap, go, hrdn, hrdn_chg
    );

    modport slave (
        input  pause, lock, start, lft, rgt, sw,
        output tick, sw_level, tap, go, hrdn, hrdn_chg
    );
endinterface

// File: rtl/wam_debounce.sv
// Single-lane tick-sampled debouncer with a one-cycle registered rising-edge pulse.
module wam_debounce
    import wam_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES = WAM_DEB_SAMPLES
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic rise
);
    logic [DEB_SAMPLES-1:0] r_hist;
    logic [DEB_SAMPLES-1:0] w_hist_nxt;
    logic                   r_level;
    logic                   r_level_q;
    logic                   r_rise;

    assign w_hist_nxt = {r_hist[DEB_SAMPLES-2:0], din};

    always_ff @(posedge clk) begin
        if (clr) begin
            r_hist    <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_level_q <= r_level;
            r_rise    <= r_level & ~r_level_q;
            if (tick) begin
                r_hist <= w_hist_nxt;
                // Mixed histories hold the previous level.
                if (&w_hist_nxt) begin
                    r_level <= 1'b1;
                end else if (~|w_hist_nxt) begin
                    r_level <= 1'b0;
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
endmodule

// File: rtl/wam_panel_io.sv
// Front-panel input controller: scan tick, synchronise and debounce switches/buttons,
// emit tap/go pulses and track the saturating difficulty level.
module wam_panel_io
    import wam_pkg::*;
#(
    parameter int unsigned N_CH          = WAM_N_CH,
    parameter int unsigned SCAN_DIV_LOG2 = WAM_SCAN_DIV_LOG2,
    parameter int unsigned DEB_SAMPLES   = WAM_DEB_SAMPLES,
    parameter int unsigned LEVELS        = WAM_LEVELS,
    parameter int unsigned LVL_W         = WAM_LVL_W,
    parameter int unsigned LVL_INIT      = LVL_EASY
) (
    input logic           clk,
    input logic           clr,
    wam_panel_io_if.slave bus
);
    localparam int unsigned NL = N_CH + LANE_BTN_CNT;

    logic [SCAN_DIV_LOG2-1:0] r_presc;
    logic                     w_tick;
    logic [NL-1:0]            w_raw;
    logic [NL-1:0]            r_sync1;
    logic [NL-1:0]            r_sync2;
    logic [NL-1:0]            w_level;
    logic [NL-1:0]            w_rise;
    logic                     w_up;
    logic                     w_dn;
    logic [LVL_W-1:0]         r_hrdn;
    logic                     r_hrdn_chg;
    logic                     w_unused_btn_lvl;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + SCAN_DIV_LOG2'(1);
        end
    end

    // The prescaler free-runs; pause only masks the strobe, so a paused wrap is simply lost.
    assign w_tick = (r_presc == '1) & ~bus.pause;

    assign w_raw = {bus.rgt, bus.lft, bus.start, bus.sw};

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < NL; gi++) begin : g_deb
        wam_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk  (clk),
            .clr  (clr),
            .tick (w_tick),
            .din  (r_sync2[gi]),
            .level(w_level[gi]),
            .rise (w_rise[gi])
        );
    end

    assign w_up = w_rise[N_CH + LANE_RGT_OFS];
    assign w_dn = w_rise[N_CH + LANE_LFT_OFS];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_hrdn     <= LVL_W'(LVL_INIT);
            r_hrdn_chg <= 1'b0;
        end else begin
            r_hrdn_chg <= 1'b0;
            // Simultaneous lft/rgt edges cancel; edges while locked are dropped, not deferred.
            if (!bus.lock && (w_up != w_dn)) begin
                if (w_up && (r_hrdn != LVL_W'(LEVELS - 1))) begin
                    r_hrdn     <= r_hrdn + LVL_W'(1);
                    r_hrdn_chg <= 1'b1;
                end else if (w_dn && (r_hrdn != '0)) begin
                    r_hrdn     <= r_hrdn - LVL_W'(1);
                    r_hrdn_chg <= 1'b1;
                end
            end
        end
    end

    assign bus.tick     = w_tick;
    assign bus.sw_level = w_level[N_CH-1:0];
    assign bus.tap      = w_rise[N_CH-1:0] & {N_CH{~bus.pause}};
    assign bus.go       = w_rise[N_CH + LANE_START_OFS] & ~bus.pause;
    assign bus.hrdn     = r_hrdn;
    assign bus.hrdn_chg = r_hrdn_chg;

    assign w_unused_btn_lvl = ^w_level[NL-1:N_CH];
endmodule

// File: tb/tb_wam_panel_io.sv
// Randomised and directed bench for wam_panel_io against a run-length behavioural model.
module tb_wam_panel_io;
    localparam int N_CH          = 8;
    localparam int SCAN_DIV_LOG2 = 3;
    localparam int DEB_SAMPLES   = 4;
    localparam int LEVELS        = 3;
    localparam int LVL_W         = 4;
    localparam int LVL_INIT      = 0;
    localparam int PERIOD        = 1 << SCAN_DIV_LOG2;
    localparam int NDB           = N_CH + 3;
    localparam int VW            = 1 + N_CH + N_CH + 1 + LVL_W + 1;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic            pause = 1'b0;
    logic            lock = 1'b0;
    logic            start = 1'b0;
    logic            lft = 1'b0;
    logic            rgt = 1'b0;
    logic [N_CH-1:0] sw = '0;

    int n_checks = 0;
    int n_fail   = 0;

    wam_panel_io_if #(.N_CH(N_CH), .LVL_W(LVL_W)) bus ();

    assign bus.pause = pause;
    assign bus.lock  = lock;
    assign bus.start = start;
    assign bus.lft   = lft;
    assign bus.rgt   = rgt;
    assign bus.sw    = sw;

    wam_panel_io #(
        .N_CH         (N_CH),
        .SCAN_DIV_LOG2(SCAN_DIV_LOG2),
        .DEB_SAMPLES  (DEB_SAMPLES),
        .LEVELS       (LEVELS),
        .LVL_W        (LVL_W),
        .LVL_INIT     (LVL_INIT)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {bus.tick, bus.sw_level, bus.tap, bus.go, bus.hrdn, bus.hrdn_chg};

    // Model: each lane keeps the value and length of its current run of tick samples.
    int           m_cnt;
    bit [NDB-1:0] m_q1, m_q2, m_runv, m_stable, m_rose, m_rise, m_raw, m_rise_old;
    int           m_runl [NDB];
    int           m_hrdn;
    bit           m_chg;
    bit           m_tk;

    always @(posedge clk) begin
        m_raw = {rgt, lft, start, sw};
        if (clr) begin
            m_cnt = 0; m_q1 = '0; m_q2 = '0; m_runv = '0; m_stable = '0;
            m_rose = '0; m_rise = '0; m_hrdn = LVL_INIT; m_chg = 1'b0;
            for (int i = 0; i < NDB; i++) m_runl[i] = DEB_SAMPLES;
        end else begin
            m_tk       = (m_cnt == PERIOD - 1) && !pause;
            m_rise_old = m_rise;
            m_rise     = m_rose;
            m_rose     = '0;
            if (m_tk) begin
                for (int i = 0; i < NDB; i++) begin
                    if (m_q2[i] == m_runv[i]) m_runl[i]++;
                    else begin m_runv[i] = m_q2[i]; m_runl[i] = 1; end
                    if (m_runl[i] >= DEB_SAMPLES && m_stable[i] != m_runv[i]) begin
                        m_rose[i]   = m_runv[i];
                        m_stable[i] = m_runv[i];
                    end
                end
            end
            m_q2  = m_q1;
            m_q1  = m_raw;
            m_chg = 1'b0;
            if (!lock && (m_rise_old[NDB-1] != m_rise_old[NDB-2])) begin
                if (m_rise_old[NDB-1] && m_hrdn < LEVELS - 1) begin m_hrdn++; m_chg = 1'b1; end
                else if (m_rise_old[NDB-2] && m_hrdn > 0) begin m_hrdn--; m_chg = 1'b1; end
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [N_CH-1:0] tp;
        tp = m_rise[N_CH-1:0] & {N_CH{~pause}};
        return {(m_cnt == PERIOD - 1) && !pause, m_stable[N_CH-1:0], tp,
                m_rise[N_CH] & ~pause, LVL_W'(m_hrdn), m_chg};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_btns(input bit s, input bit l, input bit r, input int n,
                             output int chg, output int gos);
        start = s; lft = l; rgt = r; chg = 0; gos = 0;
        repeat (n) begin
            cyc();
            chg += int'(bus.hrdn_chg);
            gos += int'(bus.go);
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] rv;
        clr = 1'b1; pause = 0; lock = 0; start = 0; lft = 0; rgt = 0; sw = '0;
        repeat (3) cyc();
        rv = '0;
        rv[LVL_W:1] = LVL_W'(LVL_INIT);
        n_checks++;
        if (dut_vec !== rv) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, rv);
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        end
        clr = 1'b0;
    endtask

    task automatic test_sw_tap();
        int first = -1, pulses = 0, other = 0;
        logic [N_CH-1:0] mask;
        mask = '1; mask[2] = 1'b0;
        for (int k = 0; k < 2 * PERIOD && m_cnt != 0; k++) cyc();
        sw[2] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL sw_tap_model @%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            if (bus.tap[2]) begin pulses++; if (first < 0) first = c; end
            if ((bus.tap & mask) != '0) other++;
        end
        n_checks++;
        if (bus.sw_level[2] !== 1'b1) begin n_fail++; $display("FAIL sw2_level: got %b expected 1", bus.sw_level[2]); end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL sw2_tap_count: got %0d expected 1", pulses); end
        n_checks++;
        if (first < 32 || first > 45) begin n_fail++; $display("FAIL sw2_tap_latency: got %0d expected 32..45", first); end
        n_checks++;
        if (other != 0) begin n_fail++; $display("FAIL sw2_other_taps: got %0d expected 0", other); end
        sw[2] = 1'b0;
        repeat (40) cyc();
        n_checks++;
        if (bus.sw_level[2] !== 1'b0) begin n_fail++; $display("FAIL sw2_release: got %b expected 0", bus.sw_level[2]); end
    endtask

    task automatic test_bounce();
        int taps = 0, lvl = 0;
        sw[5] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c > 0 && c % 9 == 0) sw[5] = ~sw[5];
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_model @%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            taps += int'(bus.tap[5]);
            lvl  += int'(bus.sw_level[5]);
        end
        n_checks++;
        if (taps != 0) begin n_fail++; $display("FAIL bounce_tap: got %0d expected 0", taps); end
        n_checks++;
        if (lvl != 0) begin n_fail++; $display("FAIL bounce_level: got %0d expected 0", lvl); end
        sw[5] = 1'b0;
        repeat (40) cyc();
    endtask

    task automatic test_level();
        int exp_h [3] = '{1, 2, 2};
        int chg, gos, total = 0;
        lock = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hold_btns(0, 0, 1, 40, chg, gos); total += chg;
            hold_btns(0, 0, 0, 40, chg, gos); total += chg;
            n_checks++;
            if (bus.hrdn !== LVL_W'(exp_h[k])) begin
                n_fail++; $display("FAIL rgt_press%0d: got %0d expected %0d", k, bus.hrdn, exp_h[k]);
            end
            n_checks++;
            if (bus.hrdn !== LVL_W'(m_hrdn)) begin
                n_fail++; $display("FAIL rgt_model%0d: got %0d expected %0d", k, bus.hrdn, m_hrdn);
            end
        end
        n_checks++;
        if (total != 2) begin n_fail++; $display("FAIL rgt_chg_count: got %0d expected 2", total); end
        hold_btns(0, 1, 0, 40, chg, gos); total = chg;
        hold_btns(0, 0, 0, 40, chg, gos); total += chg;
        n_checks++;
        if (bus.hrdn !== LVL_W'(1)) begin n_fail++; $display("FAIL lft_press: got %0d expected 1", bus.hrdn); end
        n_checks++;
        if (total != 1) begin n_fail++; $display("FAIL lft_chg_count: got %0d expected 1", total); end
    endtask

    task automatic test_lock();
        int chg, gos, total;
        lock = 1'b1;
        hold_btns(0, 0, 1, 40, chg, gos); total = chg;
        lock = 1'b0;
        hold_btns(0, 0, 1, 20, chg, gos); total += chg;
        hold_btns(0, 0, 0, 40, chg, gos); total += chg;
        n_checks++;
        if (bus.hrdn !== LVL_W'(1)) begin n_fail++; $display("FAIL lock_hrdn: got %0d expected 1", bus.hrdn); end
        n_checks++;
        if (total != 0) begin n_fail++; $display("FAIL lock_chg: got %0d expected 0", total); end
        hold_btns(0, 1, 1, 40, chg, gos); total = chg;
        hold_btns(0, 0, 0, 40, chg, gos); total += chg;
        n_checks++;
        if (bus.hrdn !== LVL_W'(1)) begin n_fail++; $display("FAIL both_hrdn: got %0d expected 1", bus.hrdn); end
        n_checks++;
        if (total != 0) begin n_fail++; $display("FAIL both_chg: got %0d expected 0", total); end
    endtask

    task automatic test_pause();
        int ticks = 0, taps = 0, wait_c = -1;
        for (int k = 0; k < 2 * PERIOD && m_cnt != 0; k++) cyc();
        sw[0] = 1'b1;
        repeat (3 * PERIOD) cyc();
        pause = 1'b1;
        for (int c = 0; c < 64; c++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL pause_model @%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            ticks += int'(bus.tick);
            taps  += int'(bus.tap != '0);
        end
        n_checks++;
        if (ticks != 0) begin n_fail++; $display("FAIL pause_tick: got %0d expected 0", ticks); end
        n_checks++;
        if (taps != 0 || bus.sw_level[0] !== 1'b0) begin
            n_fail++; $display("FAIL pause_tap: got taps %0d level %b expected 0 0", taps, bus.sw_level[0]);
        end
        pause = 1'b0;
        for (int c = 1; c <= PERIOD + 2 && wait_c < 0; c++) begin
            cyc();
            if (bus.tap[0]) wait_c = c;
        end
        n_checks++;
        if (wait_c < 0) begin n_fail++; $display("FAIL unpause_tap: got none expected within %0d clk", PERIOD + 2); end
        sw[0] = 1'b0;
        repeat (40) cyc();
    endtask

    task automatic test_clr_mid();
        logic [VW-1:0] rv;
        int ticks = 0, gos = 0, t_at_go = -1;
        start = 1'b1;
        repeat (10) cyc();
        clr = 1'b1;
        cyc();
        rv = '0;
        rv[LVL_W:1] = LVL_W'(LVL_INIT);
        n_checks++;
        if (dut_vec !== rv) begin n_fail++; $display("FAIL clr_outputs: got %h expected %h", dut_vec, rv); end
        clr = 1'b0;
        for (int c = 0; c < 6 * PERIOD; c++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL clr_model @%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            if (bus.go) begin gos++; if (t_at_go < 0) t_at_go = ticks; end
            ticks += int'(bus.tick);
        end
        n_checks++;
        if (gos != 1) begin n_fail++; $display("FAIL clr_go_count: got %0d expected 1", gos); end
        n_checks++;
        if (t_at_go != DEB_SAMPLES) begin
            n_fail++; $display("FAIL clr_go_ticks: got %0d expected %0d", t_at_go, DEB_SAMPLES);
        end
        start = 1'b0;
        repeat (40) cyc();
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                clr = 1'b1; len = 1;
            end else begin
                clr   = 1'b0;
                sw    = N_CH'($urandom);
                start = ($urandom_range(0, 3) == 0);
                lft   = ($urandom_range(0, 3) == 0);
                rgt   = ($urandom_range(0, 2) == 0);
                lock  = ($urandom_range(0, 3) == 0);
                pause = ($urandom_range(0, 5) == 0);
                len   = $urandom_range(4, 50);
            end
            repeat (len) begin
                cyc();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL random_model @%0t: got %h expected %h", $time, dut_vec, exp_vec());
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sw_tap();
        test_bounce();
        test_level();
        test_lock();
        test_pause();
        test_clr_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
